// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parameterised register file.
// Imported by the interface, the clear sequencer and the top.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: one write port, NRD packed read ports and the busy flag.
// The master drives writes and read addresses; the slave returns data and busy.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
);

  logic                     RegWrite;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NRD*ADDR_W-1:0]    raddr;
  logic [NRD*DATA_W-1:0]    rdata;
  logic                     busy;

  modport master (
    output RegWrite, waddr, wdata, raddr,
    input  rdata, busy
  );

  modport slave (
    input  RegWrite, waddr, wdata, raddr,
    output rdata, busy
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks entries 0..DEPTH-1 writing zero, then parks in RUN.
// busy_o also rises combinationally while rst_n is low so nothing leaks during reset.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy_o,
  output logic              clear_we_o,
  output logic [ADDR_W-1:0] clear_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clear_we_o = 1'b0;
    busy_o     = ~rst_n;
    case (state_q)
      CLEAR: begin
        busy_o     = 1'b1;
        clear_we_o = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clear_addr_o = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file: zero-latency reads on NRD ports, entry 0 hard-wired to zero,
// self-clearing after reset. Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input  logic      clk,
  input  logic      rst_n,
  regfile_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic              busy;
  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              run_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NRD*DATA_W-1:0] rdata_all;

  logic [DATA_W-1:0] mem_q [DEPTH];

  regfile_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk          (clk),
    .rst_n        (rst_n),
    .busy_o       (busy),
    .clear_we_o   (clear_we),
    .clear_addr_o (clear_addr)
  );

  // A user write only lands outside the sweep, off entry 0 and inside the array.
  assign run_we = bus.RegWrite && !busy && (bus.waddr != '0)
                  && ({1'b0, bus.waddr} < DEPTH_X);

  assign mem_we    = clear_we || run_we;
  assign mem_waddr = clear_we ? clear_addr : bus.waddr;
  assign mem_wdata = clear_we ? '0 : bus.wdata;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = bus.raddr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd = '0;
        if (!busy && (ra != '0) && ({1'b0, ra} < DEPTH_X)) begin
          rd = mem_q[ra];
        end
`ifdef REGFILE_BYPASS_EN
        if (run_we && (ra == bus.waddr)) begin
          rd = bus.wdata;
        end
`endif
      end

      assign rdata_all[gi*DATA_W +: DATA_W] = rd;
    end
  endgenerate

  assign bus.rdata = rdata_all;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a DEPTH=32/NRD=2 instance and a DEPTH=24/NRD=3 instance.
// Expected values track the REGFILE_BYPASS_EN build setting.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus_a ();
  regfile_if #(.DATA_W(32), .ADDR_W(5), .NRD(3)) bus_b ();

  regfile_param #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NRD(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  regfile_param #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .NRD(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;   // expected without bypass
    logic [31:0] e1;
    logic [31:0] b0;   // expected with bypass
    logic [31:0] b1;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero_a(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus_a.raddr = {5'(31 - i), 5'(i)};
      #1;
      check({tag, "_p0"}, bus_a.rdata[31:0], 32'h0);
      check({tag, "_p1"}, bus_a.rdata[63:32], 32'h0);
    end
    $display("zero scan %s done", tag);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int cyc;
    logic [31:0] x0;
    logic [31:0] x1;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'h11,       5'd7,  5'd6,  32'h0,        32'h0,        32'h11,       32'h0};
    vecs[5]  = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd5,  32'h11,       32'hDEADBEEF, 32'h22,       32'hDEADBEEF};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       32'h22,       32'h22};
    vecs[7]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'h0,        32'h0,        32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'hA5A5A5A5, 32'h22,       32'hA5A5A5A5, 32'h22};
    vecs[9]  = '{1'b1, 5'd6,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h22,       32'hDEADBEEF, 32'h22};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd6,  5'd31, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};

    rst_n          = 1'b0;
    bus_a.RegWrite = 1'b0;
    bus_a.waddr    = '0;
    bus_a.wdata    = '0;
    bus_a.raddr    = {5'd5, 5'd3};
    bus_b.RegWrite = 1'b0;
    bus_b.waddr    = '0;
    bus_b.wdata    = '0;
    bus_b.raddr    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_a", 32'(bus_a.busy), 32'd1);
    check("rst_busy_b", 32'(bus_b.busy), 32'd1);
    check("rst_rd_a", bus_a.rdata[31:0], 32'h0);
    $display("reset applied busy_a=%0b busy_b=%0b", bus_a.busy, bus_b.busy);

    // Release and measure sweep length of both instances
    rst_n = 1'b1;
    cnt_a = -1;
    cnt_b = -1;
    cyc   = 0;
    while ((cnt_a < 0 || cnt_b < 0) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cnt_a < 0 && !bus_a.busy) cnt_a = cyc;
      if (cnt_b < 0 && !bus_b.busy) cnt_b = cyc;
    end
    check("sweep_len_a", 32'(cnt_a), 32'd32);
    check("sweep_len_b", 32'(cnt_b), 32'd24);
    $display("sweep done: a=%0d cycles b=%0d cycles", cnt_a, cnt_b);
    check_zero_a("post_sweep");

    // Table-driven read/write vectors on instance A
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      bus_a.RegWrite = vecs[i].we;
      bus_a.waddr    = vecs[i].wa;
      bus_a.wdata    = vecs[i].wd;
      bus_a.raddr    = {vecs[i].ra1, vecs[i].ra0};
      @(negedge clk);
      x0 = BYP ? vecs[i].b0 : vecs[i].e0;
      x1 = BYP ? vecs[i].b1 : vecs[i].e1;
      check($sformatf("vec%0d_p0", i), bus_a.rdata[31:0], x0);
      check($sformatf("vec%0d_p1", i), bus_a.rdata[63:32], x1);
      $display("vec %0d we=%0b wa=%0d wd=%h ra=%0d/%0d rd=%h/%h",
               i, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1,
               bus_a.rdata[31:0], bus_a.rdata[63:32]);
    end
    @(posedge clk);
    #1;
    bus_a.RegWrite = 1'b0;

    // Reset from RUN, then again at sweep index 10
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_a.raddr = {5'd7, 5'd31};
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", 32'(bus_a.busy), 32'd1);
    check("mid_rd31", bus_a.rdata[31:0], 32'h0);
    check("mid_rd7", bus_a.rdata[63:32], 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt_a = 0;
    while (bus_a.busy && cnt_a < 100) begin
      @(posedge clk);
      #1;
      cnt_a++;
      if (cnt_a >= 20 && cnt_a < 30) begin
        bus_a.RegWrite = 1'b1;
        bus_a.waddr    = 5'd3;
        bus_a.wdata    = 32'hAAAA_AAAA;
        bus_a.raddr    = {5'd31, 5'd3};
        #1;
        check("busy_rd3", bus_a.rdata[31:0], 32'h0);
      end else begin
        bus_a.RegWrite = 1'b0;
      end
    end
    bus_a.RegWrite = 1'b0;
    check("resweep_len", 32'(cnt_a), 32'd32);
    $display("restart sweep: %0d cycles", cnt_a);
    check_zero_a("post_restart");

    // Instance B: out-of-range write/read and three concurrent ports
    @(posedge clk);
    #1;
    bus_b.RegWrite = 1'b1;
    bus_b.waddr    = 5'd30;
    bus_b.wdata    = 32'hBAD0BAD0;
    bus_b.raddr    = {5'd30, 5'd30, 5'd30};
    @(negedge clk);
    check("b_oor_same", bus_b.rdata[31:0], 32'h0);
    $display("b write addr 30 rd=%h", bus_b.rdata[31:0]);
    @(posedge clk);
    #1;
    bus_b.waddr = 5'd3;
    bus_b.wdata = 32'h33;
    @(posedge clk);
    #1;
    bus_b.waddr = 5'd10;
    bus_b.wdata = 32'h1010;
    @(posedge clk);
    #1;
    bus_b.waddr = 5'd23;
    bus_b.wdata = 32'h2323;
    @(posedge clk);
    #1;
    bus_b.RegWrite = 1'b0;
    bus_b.raddr    = {5'd3, 5'd10, 5'd23};
    #1;
    check("b_p0_23", bus_b.rdata[31:0],  32'h2323);
    check("b_p1_10", bus_b.rdata[63:32], 32'h1010);
    check("b_p2_3",  bus_b.rdata[95:64], 32'h33);
    $display("b read 23/10/3 rd=%h/%h/%h", bus_b.rdata[31:0], bus_b.rdata[63:32], bus_b.rdata[95:64]);
    bus_b.raddr = {5'd0, 5'd24, 5'd30};
    #1;
    check("b_rd30", bus_b.rdata[31:0],  32'h0);
    check("b_rd24", bus_b.rdata[63:32], 32'h0);
    check("b_rd0",  bus_b.rdata[95:64], 32'h0);
    $display("b read 30/24/0 rd=%h/%h/%h", bus_b.rdata[31:0], bus_b.rdata[63:32], bus_b.rdata[95:64]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
- REQ-001: Parameter DATA_W, default 32, width of each register in bits.
- REQ-002: Parameter DEPTH, default 32, number of registers; legal range 2..256.
- REQ-003: Parameter ADDR_W, default 5, address width; SHALL equal ceil(log2(DEPTH)).
- REQ-004: Parameter NRD, default 2, number of independent read ports; legal range 1..4.
- REQ-005: clk  input  1  single clock; all state updates on rising edge.
- REQ-006: rst_n  input  1  synchronous, active-low reset.
- REQ-007: RegWrite  input  1  write enable; write occurs when high and block not busy.
- REQ-008: waddr  input  ADDR_W  write address.
- REQ-009: wdata  input  DATA_W  write data.
- REQ-010: raddr  input  NRD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- REQ-011: rdata  output  NRD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
- REQ-012: busy  output  1  high while the post-reset clear sweep is in progress.

Function
- REQ-013: Two-state FSM, CLEAR and RUN; CLEAR -> RUN on the cycle the sweep counter writes entry DEPTH-1; RUN is held until reset.
- REQ-014: In CLEAR, one entry per cycle SHALL be written to zero, ascending from index 0; the sweep takes exactly DEPTH cycles after rst_n goes high.
- REQ-015: busy SHALL be 1 in CLEAR and 0 in RUN; first cycle with busy=0 is cycle DEPTH after rst_n deassertion.
- REQ-016: In CLEAR, RegWrite SHALL be ignored and every rdata port SHALL read 0.
- REQ-017: In RUN, when RegWrite=1, wdata SHALL be stored at waddr on the rising edge.
- REQ-018: Entry 0 SHALL always read 0; writes to address 0 SHALL be discarded.
- REQ-019: Writes with waddr >= DEPTH SHALL be discarded; reads with raddr >= DEPTH SHALL return 0.
- REQ-020: Reads SHALL be combinational (zero latency) from the array.
- REQ-021: Several read ports addressing the same entry SHALL all return the same value.
- REQ-022: A read in the same cycle as a write to the same address returns the old value unless REGFILE_BYPASS_EN is defined (REQ-026).

Reset
- REQ-023: While rst_n=0 at a rising edge: FSM -> CLEAR, sweep counter -> 0, busy=1, all rdata=0.
- REQ-024: Reset asserted mid-sweep or in RUN SHALL restart the full sweep from index 0 once rst_n returns high.
- REQ-025: Array contents are undefined until the sweep completes; no initial-block preload.

Configuration
- REQ-026: With macro REGFILE_BYPASS_EN defined: in RUN, if RegWrite=1, waddr!=0, waddr<DEPTH and raddr[k]==waddr, rdata[k] SHALL equal wdata in that cycle. Without it: rdata[k] returns the stored (pre-write) value; no bypass logic is built.

Structure
- REQ-027: Package regfile_pkg SHALL hold the FSM state type (CLEAR, RUN) and the default constants for DATA_W, DEPTH, ADDR_W, NRD.
- REQ-028: Sub-module regfile_clear_fsm SHALL contain the FSM, sweep counter and busy; it outputs the clear-write enable and clear address to the top.
- REQ-029: Read ports SHALL be built with a generate loop over NRD.

Verification
- REQ-030: Reset release, DEPTH=32 -> busy=1 for exactly 32 cycles, then 0; every entry reads 0 afterwards.
- REQ-031: RUN, write 0xDEADBEEF to addr 5, next cycle raddr0=5, raddr1=5 -> both ports read 0xDEADBEEF.
- REQ-032: Write 0xFFFFFFFF to addr 0 -> addr 0 still reads 0.
- REQ-033: Addr 7 holds 0x11; same cycle write 0x22 to addr 7 with raddr0=7 -> reads 0x22 with REGFILE_BYPASS_EN, 0x11 without; following cycle 0x22 both builds.
- REQ-034: Assert rst_n=0 at sweep index 10, release -> busy held for a full 32 more cycles; RegWrite pulses during busy leave the array all zero.
- REQ-035: DEPTH=24, ADDR_W=5, NRD=3: write to addr 30 discarded and raddr 30 reads 0; three distinct addresses read concurrently return their values.
